// File: rtl/conv33_window_if.sv
// Pixel stream in, 3x3 window taps and strobes out, for conv33_window.
interface conv33_window_if #(
  parameter int DATA_WIDTH = 8
);
  logic signed [DATA_WIDTH-1:0] pix_in;
  logic                         pix_valid;
  logic signed [DATA_WIDTH-1:0] data_0_0, data_0_1, data_0_2;
  logic signed [DATA_WIDTH-1:0] data_1_0, data_1_1, data_1_2;
  logic signed [DATA_WIDTH-1:0] data_2_0, data_2_1, data_2_2;
  logic                         conv33_en;
  logic                         frame_done;

  modport master (
    output pix_in, pix_valid,
    input  data_0_0, data_0_1, data_0_2,
    input  data_1_0, data_1_1, data_1_2,
    input  data_2_0, data_2_1, data_2_2,
    input  conv33_en, frame_done
  );

  modport slave (
    input  pix_in, pix_valid,
    output data_0_0, data_0_1, data_0_2,
    output data_1_0, data_1_1, data_1_2,
    output data_2_0, data_2_1, data_2_2,
    output conv33_en, frame_done
  );
endinterface

// File: rtl/conv33_window.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 register window,
// flagging each valid unpadded stride-1 neighbourhood for conv33_calc.
module conv33_window #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  conv33_window_if.slave   bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic signed [DATA_WIDTH-1:0] lb1 [IMG_W];
  logic signed [DATA_WIDTH-1:0] lb2 [IMG_W];
  logic signed [DATA_WIDTH-1:0] win [3][3];
  logic signed [DATA_WIDTH-1:0] lb_a, lb_b;

  logic accept, col_end, row_end, win_ok;
  logic en_q, done_q;

  always_comb begin
    accept  = bus.pix_valid & ~clear;
    col_end = (col == COL_LAST);
    row_end = (row == ROW_LAST);
    win_ok  = (row >= RW'(2)) && (col >= CW'(2));
    lb_a    = lb2[col];
    lb_b    = lb1[col];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (bus.pix_valid) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // No reset: stale rows are masked by the row >= 2 gate, so this can map to RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col] <= lb_b;
      lb1[col] <= bus.pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (accept) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb_a;
      win[1][2] <= lb_b;
      win[2][2] <= bus.pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      en_q   <= accept && win_ok;
      done_q <= accept && win_ok && row_end && col_end;
    end
  end

  assign bus.data_0_0   = win[0][0];
  assign bus.data_0_1   = win[0][1];
  assign bus.data_0_2   = win[0][2];
  assign bus.data_1_0   = win[1][0];
  assign bus.data_1_1   = win[1][1];
  assign bus.data_1_2   = win[1][2];
  assign bus.data_2_0   = win[2][0];
  assign bus.data_2_1   = win[2][1];
  assign bus.data_2_2   = win[2][2];
  assign bus.conv33_en  = en_q;
  assign bus.frame_done = done_q;
endmodule

// File: doc/conv33_window.md
# conv33_window

Streaming 3x3 window generator that sits directly upstream of `conv33_calc`. It accepts a raster-order pixel stream of one feature-map channel. Two line buffers and a 3x3 register window assemble each valid (unpadded, stride-1) 3x3 neighbourhood. It presents the nine taps `data_0_0..data_2_2` together with a one-cycle `conv33_en` strobe, which `conv33_calc` consumes unchanged.

## Interface
- `DATA_WIDTH`, default 8: pixel width, signed; matches the `conv33_calc` data inputs.
- `IMG_W`, default 28: pixels per row, minimum 3.
- `IMG_H`, default 28: rows per frame, minimum 3.
- `clk`  in  1: the single clock; everything is rising-edge.
- `rst`  in  1: asynchronous, active-low reset.
- `clear`  in  1: synchronous restart. Resets the counters and drops `conv33_en`; the window and line-buffer contents are left as they are.
- `pix_in`  in  DATA_WIDTH: input pixel, signed.
- `pix_valid`  in  1: `pix_in` is accepted on every clock edge where this is high. There is no backpressure.
- `data_r_c` (r, c = 0..2)  out  DATA_WIDTH each: window taps. r=0 is the oldest row (top), c=0 is the oldest column (left), so `data_2_2` is the most recently accepted pixel.
- `conv33_en`  out  1: window valid, one cycle per complete window.
- `frame_done`  out  1: one-cycle pulse, coincident with the last window of a frame.

## Operation
- Counters: `col` runs 0..IMG_W-1 and `row` runs 0..IMG_H-1. Both track the position of the pixel being accepted.
  - On acceptance, `col` increments.
  - At IMG_W-1, `col` wraps to 0 and `row` increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and the next frame begins with no gap cycle.
- Line buffers: `lb1` and `lb2`, each IMG_W x DATA_WIDTH.
  - On acceptance at column c, read `a = lb2[c]` and `b = lb1[c]`, then write `lb2[c] <= b` and `lb1[c] <= pix_in`.
  - So `lb1` holds row−1 and `lb2` holds row−2, both aligned by column.
- Window shift on acceptance:
  - Column 0 takes the old column 1, and column 1 takes the old column 2.
  - Column 2 loads `{data_0_2, data_1_2, data_2_2} <= {a, b, pix_in}`.
- Validity: `conv33_en` is asserted in the cycle after accepting a pixel with row ≥ 2 and col ≥ 2.
  - This gives exactly (IMG_H−2)·(IMG_W−2) strobes per frame.
  - Windows straddling a row boundary (col < 2) are never flagged.
- `frame_done`: asserted in the same cycle as `conv33_en` for the window completed by pixel (IMG_H−1, IMG_W−1).
- Stale contents:
  - Line-buffer contents from the previous frame, or from before a `clear`, are never exposed in a flagged window, because the row ≥ 2 gate applies.
  - The line buffers need no reset and may be inferred as RAM. A read-before-write at the same address within one cycle is required.

## Timing
- Reset values: all `data_r_c` = 0, `conv33_en` = 0, `frame_done` = 0, `col` = 0, `row` = 0.
- Reset mid-frame: the next accepted pixel is treated as (0,0).
- Latency: window taps and `conv33_en` are registered outputs and are valid one clock after the edge that accepts the completing pixel.
- `conv33_en` is high for exactly one cycle per window.
- `pix_valid` low:
  - No shift, no counter change, `conv33_en` = 0 next cycle.
  - Taps hold their last value.
- Back-to-back `pix_valid`: windows are produced at up to one per cycle.
- `clear` together with `pix_valid`: `clear` wins.
  - The pixel is dropped.
  - Counters go to (0,0).
  - `conv33_en` and `frame_done` are 0 next cycle.
- Arithmetic: none on the data path. Pixels pass through bit-exact, sign preserved.
- Counter widths are `$clog2` of the corresponding dimension.

## Test plan
Unless stated otherwise, IMG_W=4 and IMG_H=4, with pixels 1..16 in raster order.

- Reset: hold `rst` low, then release.
  - All outputs are 0.
  - No `conv33_en` before the 11th pixel.
- Full frame, continuous `pix_valid`: exactly 4 `conv33_en` pulses, one cycle after pixels 11, 12, 15 and 16.
  - Rows {1,2,3}/{5,6,7}/{9,10,11}.
  - Then {2,3,4}/{6,7,8}/{10,11,12}.
  - Then {5,6,7}/{9,10,11}/{13,14,15}.
  - Then {6,7,8}/{10,11,12}/{14,15,16}, with `frame_done` high on this one only.
- Gapped input: same stream with `pix_valid` toggling every other cycle.
  - Identical windows and order.
  - Taps hold during gaps.
  - `conv33_en` is never high two cycles in a row.
- Back-to-back frames: second frame uses pixels 17..32.
  - First window of the second frame is {17,18,19}/{21,22,23}/{25,26,27}.
  - No window ever mixes pixels from both frames.
- Signed data: pixels −128, 127 and −1 propagate unchanged to `data_r_c`.
- `clear` / `rst` mid-frame: assert after pixel 9.
  - No strobe follows the abort.
  - A fresh frame 1..16 reproduces the four windows above exactly.
